control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  level; leaves IDLE when high.
REQ-004 irout  input  32  instruction register contents from datapath.
REQ-005 readim  output  1  instruction memory read enable.
REQ-006 ldir  output  1  load instruction register.
REQ-007 ldnpc  output  1  load NPC register.
REQ-008 ldA  output  1  load A register.
REQ-009 ldB  output  1  load B register.
REQ-010 ldimm  output  1  load immediate register.
REQ-011 opcond  output  2  branch condition: 00 none (selects NPC), 01 zero, 10 nonzero.
REQ-012 alusel1  output  1  ALU input 1: 0 = NPC, 1 = A.
REQ-013 alusel2  output  1  ALU input 2: 0 = B, 1 = imm.
REQ-014 aluen  output  1  ALU enable.
REQ-015 ldaluout  output  1  load ALU output register.
REQ-016 alufunc  output  4  ALU function; 4'b0000 = ADD.
REQ-017 seldest  output  1  destination register: 0 = irout[15:11], 1 = irout[20:16].
REQ-018 regwrite  output  1  register bank write enable.
REQ-019 writedmem  output  1  data memory write.
REQ-020 readdmem  output  1  data memory read.
REQ-021 ldlmd  output  1  load LMD register.
REQ-022 selwb  output  1  writeback source: 0 = LMD, 1 = ALU out.
REQ-023 branch  output  1  PC source: 0 = condition mux, 1 = NPC+offset adder.
REQ-024 ldpc  output  1  load PC.
REQ-025 halted  output  1  high while in HALT.
REQ-026 instr_count  output  32  retired-instruction count (see Configuration).

Function
REQ-027 Opcode irout[31:26]: 000000 R-type (alufunc = irout[3:0]), 000001 ADDI, 000010 LW, 000011 SW, 000100 BR, 000101 BZ, 000110 BNZ, 111111 HALT; any other opcode SHALL execute as NOP (IF, ID, EX, WB with regwrite=0).
REQ-028 FSM states IDLE, IF, ID, EX, MEM, WB, HALT; Moore outputs; every output not listed for a state is 0.
REQ-029 IDLE: -> IF when start=1, else stay.
REQ-030 IF: readim, ldir, ldnpc = 1; -> ID.
REQ-031 ID: ldA, ldB, ldimm = 1; HALT opcode -> HALT, else -> EX.
REQ-032 EX: aluen, ldaluout = 1; R: alusel1=1, alusel2=0; ADDI/LW/SW: alusel1=1, alusel2=1, ADD; BZ/BNZ: alusel1=0, alusel2=1, ADD; R/ADDI/NOP -> WB, others -> MEM.
REQ-033 MEM: LW: readdmem, ldlmd -> WB; SW: writedmem, ldpc -> IF; BR: branch, ldpc -> IF; BZ/BNZ: ldpc with opcond 01/10 -> IF.
REQ-034 opcond SHALL equal the BZ/BNZ code in both EX and MEM, 00 in every other state.
REQ-035 WB: ldpc=1, opcond=00, branch=0; R: regwrite, seldest=0, selwb=1; ADDI: regwrite, seldest=1, selwb=1; LW: regwrite, seldest=1, selwb=0; -> IF.
REQ-036 HALT: halted=1, all load/write strobes 0, remains until reset; start ignored.
REQ-037 CPI fixed: R/ADDI/NOP 4, LW 5, SW/branches 4 cycles; no stalls.
REQ-038 start deassertion mid-instruction SHALL NOT stop execution; start is sampled only in IDLE.

Reset
REQ-039 reset low SHALL force IDLE immediately, all outputs 0, instr_count 0, regardless of current state.
REQ-040 First IF occurs on the first rising edge with reset high and start high, plus one cycle.

Configuration
REQ-041 PERF_CNT_EN defined: instr_count increments by 1 (wrapping at 2^32) on every exit from WB or MEM->IF; undefined: instr_count is constant 0 and no counter logic is built.

Verification
REQ-042 reset low in EX, then release, start=1 -> IDLE, then IF, all outputs 0 during reset.
REQ-043 irout=R-type ADD (funct 0000) -> IF,ID,EX,WB; WB: regwrite=1, seldest=0, selwb=1, ldpc=1.
REQ-044 LW then SW -> 5 and 4 cycles; LW MEM readdmem=ldlmd=1; SW MEM writedmem=ldpc=1, regwrite never 1.
REQ-045 BZ -> opcond=01 in EX and MEM, ldpc=1 in MEM, branch=0; BR -> branch=1 in MEM.
REQ-046 HALT opcode -> halted=1 after ID, no further ldpc; with PERF_CNT_EN, 3 prior instructions -> instr_count=3.

Source files
------------

// File: rtl/control_unit.sv
// control_unit -- multi-cycle FSM sequencer for a simple load/store datapath.
//
// Purpose:
//   Decodes the opcode held in the instruction register (irout[31:26]) and
//   steps through IDLE -> IF -> ID -> EX -> [MEM] -> [WB] -> IF, with a
//   terminal HALT state. All datapath strobes are Moore outputs of the state
//   (qualified by the opcode in EX/MEM/WB).
//
// Ports:
//   clk          in   system clock, rising-edge active
//   reset        in   asynchronous active-low reset
//   start        in   leave IDLE when high (sampled only in IDLE)
//   irout[31:0]  in   instruction register contents
//   readim, ldir, ldnpc, ldA, ldB, ldimm          out  fetch/decode strobes
//   opcond[1:0]  out  branch condition: 00 none, 01 zero, 10 nonzero
//   alusel1, alusel2, aluen, ldaluout, alufunc[3:0] out  ALU controls
//   seldest, regwrite, selwb                       out  writeback controls
//   writedmem, readdmem, ldlmd                     out  memory controls
//   branch, ldpc                                   out  PC update controls
//   halted       out  high while in HALT
//   instr_count  out  retired-instruction count
//
// Configuration:
//   PERF_CNT_EN  when defined, instr_count counts retired instructions
//                (wrapping at 2^32); otherwise it is tied to zero.

module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] irout,
    output logic        readim,
    output logic        ldir,
    output logic        ldnpc,
    output logic        ldA,
    output logic        ldB,
    output logic        ldimm,
    output logic [1:0]  opcond,
    output logic        alusel1,
    output logic        alusel2,
    output logic        aluen,
    output logic        ldaluout,
    output logic [3:0]  alufunc,
    output logic        seldest,
    output logic        regwrite,
    output logic        writedmem,
    output logic        readdmem,
    output logic        ldlmd,
    output logic        selwb,
    output logic        branch,
    output logic        ldpc,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b000010;
    localparam logic [5:0] OP_SW   = 6'b000011;
    localparam logic [5:0] OP_BR   = 6'b000100;
    localparam logic [5:0] OP_BZ   = 6'b000101;
    localparam logic [5:0] OP_BNZ  = 6'b000110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t state_q, state_d;

    logic [5:0] opcode;
    logic       is_r, is_addi, is_lw, is_sw, is_br, is_bz, is_bnz, is_halt;
    logic       needs_mem;
    logic       retire;
    logic [1:0] cond_code;

    // Register fields and immediate are consumed by the datapath, not here.
    logic       unused_irout;
    assign unused_irout = ^irout[25:4];

    assign opcode  = irout[31:26];
    assign is_r    = (opcode == OP_R);
    assign is_addi = (opcode == OP_ADDI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_br   = (opcode == OP_BR);
    assign is_bz   = (opcode == OP_BZ);
    assign is_bnz  = (opcode == OP_BNZ);
    assign is_halt = (opcode == OP_HALT);

    // Unrecognised opcodes fall through EX -> WB as a NOP.
    assign needs_mem = is_lw | is_sw | is_br | is_bz | is_bnz;
    assign cond_code = is_bz ? 2'b01 : (is_bnz ? 2'b10 : 2'b00);

    // An instruction retires on leaving WB, or on MEM -> IF (everything but LW).
    assign retire = (state_q == ST_WB) || ((state_q == ST_MEM) && !is_lw);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        readim    = 1'b0;
        ldir      = 1'b0;
        ldnpc     = 1'b0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        ldimm     = 1'b0;
        opcond    = 2'b00;
        alusel1   = 1'b0;
        alusel2   = 1'b0;
        aluen     = 1'b0;
        ldaluout  = 1'b0;
        alufunc   = 4'b0000;
        seldest   = 1'b0;
        regwrite  = 1'b0;
        writedmem = 1'b0;
        readdmem  = 1'b0;
        ldlmd     = 1'b0;
        selwb     = 1'b0;
        branch    = 1'b0;
        ldpc      = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_IF;
            end
            ST_IF: begin
                readim  = 1'b1;
                ldir    = 1'b1;
                ldnpc   = 1'b1;
                state_d = ST_ID;
            end
            ST_ID: begin
                ldA     = 1'b1;
                ldB     = 1'b1;
                ldimm   = 1'b1;
                state_d = is_halt ? ST_HALT : ST_EX;
            end
            ST_EX: begin
                aluen    = 1'b1;
                ldaluout = 1'b1;
                opcond   = cond_code;
                if (is_r) begin
                    alusel1 = 1'b1;
                    alufunc = irout[3:0];
                end else if (is_addi || is_lw || is_sw) begin
                    alusel1 = 1'b1;
                    alusel2 = 1'b1;
                end else if (is_bz || is_bnz) begin
                    // Branch target = NPC + imm.
                    alusel2 = 1'b1;
                end
                state_d = needs_mem ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                opcond = cond_code;
                if (is_lw) begin
                    readdmem = 1'b1;
                    ldlmd    = 1'b1;
                    state_d  = ST_WB;
                end else begin
                    writedmem = is_sw;
                    branch    = is_br;
                    ldpc      = 1'b1;
                    state_d   = ST_IF;
                end
            end
            ST_WB: begin
                ldpc = 1'b1;
                if (is_r) begin
                    regwrite = 1'b1;
                    selwb    = 1'b1;
                end else if (is_addi) begin
                    regwrite = 1'b1;
                    seldest  = 1'b1;
                    selwb    = 1'b1;
                end else if (is_lw) begin
                    regwrite = 1'b1;
                    seldest  = 1'b1;
                end
                state_d = ST_IF;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = retire ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_count = cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instr_count   = 32'd0;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] irout;
    logic        readim, ldir, ldnpc, ldA, ldB, ldimm;
    logic [1:0]  opcond;
    logic        alusel1, alusel2, aluen, ldaluout;
    logic [3:0]  alufunc;
    logic        seldest, regwrite, writedmem, readdmem, ldlmd, selwb;
    logic        branch, ldpc, halted;
    logic [31:0] instr_count;

    control_unit dut (
        .clk(clk), .reset(reset), .start(start), .irout(irout),
        .readim(readim), .ldir(ldir), .ldnpc(ldnpc), .ldA(ldA), .ldB(ldB),
        .ldimm(ldimm), .opcond(opcond), .alusel1(alusel1), .alusel2(alusel2),
        .aluen(aluen), .ldaluout(ldaluout), .alufunc(alufunc),
        .seldest(seldest), .regwrite(regwrite), .writedmem(writedmem),
        .readdmem(readdmem), .ldlmd(ldlmd), .selwb(selwb), .branch(branch),
        .ldpc(ldpc), .halted(halted), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout (MSB first).
    logic [24:0] obs;
    assign obs = {readim, ldir, ldnpc, ldA, ldB, ldimm, opcond, alusel1,
                  alusel2, aluen, ldaluout, alufunc, seldest, regwrite,
                  writedmem, readdmem, ldlmd, selwb, branch, ldpc, halted};

    localparam logic [24:0] B1    = 25'd1;
    localparam logic [24:0] RD    = B1 << 24;
    localparam logic [24:0] LIR   = B1 << 23;
    localparam logic [24:0] LNPC  = B1 << 22;
    localparam logic [24:0] LA    = B1 << 21;
    localparam logic [24:0] LB    = B1 << 20;
    localparam logic [24:0] LIMM  = B1 << 19;
    localparam logic [24:0] OC01  = B1 << 17;
    localparam logic [24:0] OC10  = B1 << 18;
    localparam logic [24:0] AS1   = B1 << 16;
    localparam logic [24:0] AS2   = B1 << 15;
    localparam logic [24:0] AEN   = B1 << 14;
    localparam logic [24:0] LAO   = B1 << 13;
    localparam logic [24:0] FN5   = 25'd5 << 9;
    localparam logic [24:0] SD    = B1 << 8;
    localparam logic [24:0] RW    = B1 << 7;
    localparam logic [24:0] WDM   = B1 << 6;
    localparam logic [24:0] RDM   = B1 << 5;
    localparam logic [24:0] LLMD  = B1 << 4;
    localparam logic [24:0] SWB   = B1 << 3;
    localparam logic [24:0] BRN   = B1 << 2;
    localparam logic [24:0] LPC   = B1 << 1;
    localparam logic [24:0] HLT   = B1;

    localparam logic [24:0] E_NONE   = 25'd0;
    localparam logic [24:0] E_IF     = RD | LIR | LNPC;
    localparam logic [24:0] E_ID     = LA | LB | LIMM;
    localparam logic [24:0] E_EX_R0  = AEN | LAO | AS1;
    localparam logic [24:0] E_EX_R5  = AEN | LAO | AS1 | FN5;
    localparam logic [24:0] E_EX_I   = AEN | LAO | AS1 | AS2;
    localparam logic [24:0] E_EX_BZ  = AEN | LAO | AS2 | OC01;
    localparam logic [24:0] E_EX_BNZ = AEN | LAO | AS2 | OC10;
    localparam logic [24:0] E_EX_PL  = AEN | LAO;
    localparam logic [24:0] E_M_LW   = RDM | LLMD;
    localparam logic [24:0] E_M_SW   = WDM | LPC;
    localparam logic [24:0] E_M_BR   = BRN | LPC;
    localparam logic [24:0] E_M_BZ   = LPC | OC01;
    localparam logic [24:0] E_M_BNZ  = LPC | OC10;
    localparam logic [24:0] E_WB_R   = LPC | RW | SWB;
    localparam logic [24:0] E_WB_AI  = LPC | RW | SD | SWB;
    localparam logic [24:0] E_WB_LW  = LPC | RW | SD;
    localparam logic [24:0] E_WB_NOP = LPC;

    localparam logic [31:0] I_ADD  = {6'b000000, 5'd1, 5'd2, 5'd3, 11'h000};
    localparam logic [31:0] I_R5   = {6'b000000, 5'd4, 5'd5, 5'd6, 11'h005};
    localparam logic [31:0] I_ADDI = {6'b000001, 5'd1, 5'd2, 16'h0010};
    localparam logic [31:0] I_LW   = {6'b000010, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_SW   = {6'b000011, 5'd1, 5'd2, 16'h0008};
    localparam logic [31:0] I_BR   = {6'b000100, 26'h0000020};
    localparam logic [31:0] I_BZ   = {6'b000101, 5'd1, 5'd0, 16'h0040};
    localparam logic [31:0] I_BNZ  = {6'b000110, 5'd1, 5'd0, 16'h0040};
    localparam logic [31:0] I_NOP  = {6'b001000, 26'h3FFFFFF};
    localparam logic [31:0] I_HALT = {6'b111111, 26'h0};

    int          nchecks = 0;
    int          npass   = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [24:0] exp);
        nchecks++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_cnt(input string tag);
        nchecks++;
        assert (instr_count === exp_cnt) npass++;
        else $error("FAIL %s: observed instr_count %0d expected %0d", tag, instr_count, exp_cnt);
    endtask

    task automatic retired();
`ifdef PERF_CNT_EN
        exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    // Entered with the DUT just having moved into IF; leaves it back in IF.
    task automatic run(input string tag, input logic [31:0] ir,
                       input logic [24:0] e_ex, input logic [24:0] e_mem,
                       input logic [24:0] e_wb, input bit has_mem, input bit has_wb);
        irout = ir;
        tick(); chk({tag, "_id"}, E_ID);
        tick(); chk({tag, "_ex"}, e_ex);
        if (has_mem) begin
            tick(); chk({tag, "_mem"}, e_mem);
        end
        if (has_wb) begin
            tick(); chk({tag, "_wb"}, e_wb);
        end
        tick(); chk({tag, "_if"}, E_IF);
        retired();
        chk_cnt({tag, "_cnt"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        irout = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", E_NONE);
        chk_cnt("reset_cnt");

        reset = 1'b1;
        tick(); chk("idle_hold", E_NONE);

        start = 1'b1;
        tick(); chk("first_if", E_IF);
        start = 1'b0; // execution must continue without start

        run("add",  I_ADD,  E_EX_R0,  E_NONE,  E_WB_R,   1'b0, 1'b1);
        run("r5",   I_R5,   E_EX_R5,  E_NONE,  E_WB_R,   1'b0, 1'b1);
        run("addi", I_ADDI, E_EX_I,   E_NONE,  E_WB_AI,  1'b0, 1'b1);
        run("lw",   I_LW,   E_EX_I,   E_M_LW,  E_WB_LW,  1'b1, 1'b1);
        run("sw",   I_SW,   E_EX_I,   E_M_SW,  E_NONE,   1'b1, 1'b0);
        run("bz",   I_BZ,   E_EX_BZ,  E_M_BZ,  E_NONE,   1'b1, 1'b0);
        run("bnz",  I_BNZ,  E_EX_BNZ, E_M_BNZ, E_NONE,   1'b1, 1'b0);
        run("br",   I_BR,   E_EX_PL,  E_M_BR,  E_NONE,   1'b1, 1'b0);
        run("nop",  I_NOP,  E_EX_PL,  E_NONE,  E_WB_NOP, 1'b0, 1'b1);

        // Asynchronous reset in the middle of EX.
        irout = I_ADD;
        tick(); chk("rst_id", E_ID);
        tick(); chk("rst_ex", E_EX_R0);
        #2;
        reset   = 1'b0;
        exp_cnt = 32'd0;
        #1;
        chk("rst_async", E_NONE);
        chk_cnt("rst_async_cnt");
        tick(); chk("rst_held", E_NONE);
        reset = 1'b1;
        start = 1'b1;
        #1;
        chk("rst_idle", E_NONE);
        tick(); chk("rst_to_if", E_IF);
        start = 1'b0;

        run("p1", I_ADD,  E_EX_R0, E_NONE, E_WB_R,  1'b0, 1'b1);
        run("p2", I_ADDI, E_EX_I,  E_NONE, E_WB_AI, 1'b0, 1'b1);
        run("p3", I_SW,   E_EX_I,  E_M_SW, E_NONE,  1'b1, 1'b0);

        irout = I_HALT;
        tick(); chk("halt_id", E_ID);
        tick(); chk("halt_enter", E_HLT_CHK());
        tick(); chk("halt_stay", HLT);
        start = 1'b1;
        tick(); chk("halt_start_ignored", HLT);
        tick(); chk("halt_stay2", HLT);
        chk_cnt("halt_cnt");

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

    function automatic logic [24:0] E_HLT_CHK();
        return HLT;
    endfunction

endmodule
